// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch slice: bus types, control constants,
// the fetch FSM state encoding and small PC helpers.
package cpu_defines;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int REG_W       = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [REG_W-1:0]       reg_t;

  localparam reg_t       ZERO_WORD        = '0;
  localparam logic       STOP             = 1'b1;
  localparam logic       NOT_STOP         = 1'b0;
  localparam logic       RST_ENABLE       = 1'b1;
  localparam int         EXC_ADEL_IF_BIT  = 13;
  localparam inst_addr_t RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam inst_addr_t PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    FETCH_RESET,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_e;

  function automatic logic pc_misaligned(input inst_addr_t pc);
    return pc[1:0] != 2'b00;
  endfunction

  function automatic inst_addr_t word_align(input inst_addr_t pc);
    return {pc[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_redirect_arb.sv
// Combinational flush/branch arbitration: a redirect is taken when either
// request is active; with FLUSH_PRIO=1 the exception vector wins.
module if_redirect_arb
  import cpu_defines::*;
#(
  parameter int FLUSH_PRIO = 1
) (
  input  logic       flush,
  input  inst_addr_t new_pc,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  output logic       redirect,
  output inst_addr_t target
);

  logic flush_wins;

  always_comb begin
    flush_wins = flush && ((FLUSH_PRIO == 1) || !branch_flag_i);
    redirect   = flush || branch_flag_i;
    target     = flush_wins ? new_pc : branch_target_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch-side producer for IF/ID: owns the PC, issues single-outstanding imem
// requests and presents fetched words. Optional AdEL check: IF_ADEL_EXC_EN.
module if_fetch_unit
  import cpu_defines::*;
#(
  parameter inst_addr_t RESET_PC   = RESET_PC_DEFAULT,
  parameter int         FLUSH_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [31:0] if_excepttype
);

  fetch_state_e state_q, state_d;
  inst_addr_t   pc_q, pc_d;
  logic         drop_q, drop_d;
  inst_addr_t   if_pc_q, if_pc_d;
  inst_t        if_inst_q, if_inst_d;
  logic         if_valid_q, if_valid_d;
  reg_t         exc_q, exc_d;

  logic       redirect;
  inst_addr_t target;
  logic       adel;
  logic       unused_stall;

  // Upper stall bits belong to later stages.
  assign unused_stall = ^stall[5:1];

  if_redirect_arb #(
    .FLUSH_PRIO(FLUSH_PRIO)
  ) u_redirect_arb (
    .flush          (flush),
    .new_pc         (new_pc),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .redirect       (redirect),
    .target         (target)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    exc_d      = exc_q;
    imem_req   = 1'b0;
    imem_addr  = ZERO_WORD;
    adel       = 1'b0;
`ifdef IF_ADEL_EXC_EN
    adel       = pc_misaligned(pc_q);
`endif

    unique case (state_q)
      FETCH_RESET: state_d = FETCH_REQ;

      FETCH_REQ: begin
        if (adel) begin
          // Misaligned fetch is reported in place of an instruction.
          if_pc_d    = pc_q;
          if_inst_d  = ZERO_WORD;
          if_valid_d = 1'b1;
          exc_d      = ZERO_WORD;
          exc_d[EXC_ADEL_IF_BIT] = 1'b1;
          state_d    = FETCH_HOLD;
        end else begin
          imem_req  = 1'b1;
          imem_addr = word_align(pc_q);
          if (imem_gnt) state_d = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH_REQ;
          end else begin
            if_pc_d    = pc_q;
            if_inst_d  = imem_rdata;
            if_valid_d = 1'b1;
            exc_d      = ZERO_WORD;
            pc_d       = pc_q + PC_STEP;
            state_d    = FETCH_HOLD;
          end
        end
      end

      FETCH_HOLD: begin
        if (if_valid_q && (stall[0] == NOT_STOP)) begin
          if_valid_d = 1'b0;
          state_d    = FETCH_REQ;
        end
      end

      default: state_d = FETCH_RESET;
    endcase

    // Redirect overrides everything above, including a held stall.
    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      if_pc_d    = ZERO_WORD;
      if_inst_d  = ZERO_WORD;
      exc_d      = ZERO_WORD;
      unique case (state_q)
        FETCH_REQ: begin
          if (imem_req && imem_gnt) begin
            drop_d  = 1'b1;
            state_d = FETCH_WAIT;
          end else begin
            state_d = FETCH_REQ;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = FETCH_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = FETCH_WAIT;
          end
        end
        default: state_d = FETCH_REQ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments; reset is synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= FETCH_RESET;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= ZERO_WORD;
      if_inst_q  <= ZERO_WORD;
      if_valid_q <= 1'b0;
      exc_q      <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      exc_q      <= exc_d;
    end
  end

  assign if_pc         = if_pc_q;
  assign if_inst       = if_inst_q;
  assign if_valid      = if_valid_q;
  assign if_excepttype = exc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, fetch, stall, redirects, PC wrap
// and the misaligned-fetch path (both builds of IF_ADEL_EXC_EN).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] if_excepttype;

  int vec_cnt = 0;
  int err_cnt = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_valid       (if_valid),
    .if_excepttype  (if_excepttype)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the unit in REQ at addr; grants, returns data, checks presentation.
  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data, input string tag);
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      err_cnt++;
      $display("FAIL %s_req: req=%b addr=%h, expected req=1 addr=%h", tag, imem_req, imem_addr, addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    vec_cnt++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_wait: req=%b valid=%b, expected req=0 valid=0", tag, imem_req, if_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    vec_cnt++;
    if (if_valid !== 1'b1 || if_pc !== addr || if_inst !== data || imem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_present: valid=%b pc=%h inst=%h req=%b, expected valid=1 pc=%h inst=%h req=0",
               tag, if_valid, if_pc, if_inst, imem_req, addr, data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_gnt = 1'b1;
    step(); step(); step();
    imem_gnt = 1'b0;
    vec_cnt++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_pc !== 32'h0 || if_inst !== 32'h0 ||
        if_valid !== 1'b0 || if_excepttype !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: req=%b addr=%h pc=%h inst=%h valid=%b exc=%h, expected all zero",
               imem_req, imem_addr, if_pc, if_inst, if_valid, if_excepttype);
    end
    rst = 1'b0;
    step();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin
      err_cnt++;
      $display("FAIL reset_first_req: req=%b addr=%h, expected req=1 addr=bfc00000", imem_req, imem_addr);
    end
  endtask

  task automatic test_basic_fetch();
    fetch_word(32'hBFC0_0000, 32'h3C01_0001, "basic");
    step();
    vec_cnt++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0004) begin
      err_cnt++;
      $display("FAIL basic_next: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=bfc00004",
               if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    fetch_word(32'hBFC0_0004, 32'h2402_0005, "stall");
    stall = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++;
      if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_0004 || if_inst !== 32'h2402_0005 || imem_req !== 1'b0) begin
        err_cnt++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h inst=%h req=%b, expected valid=1 pc=bfc00004 inst=24020005 req=0",
                 i, if_valid, if_pc, if_inst, imem_req);
      end
    end
    // Upper stall bits must not hold the fetch stage.
    stall = 6'b111110;
    step();
    stall = '0;
    vec_cnt++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0008) begin
      err_cnt++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=bfc00008",
               if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_in_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h8000_0100;
    step();
    branch_flag_i = 1'b0;
    vec_cnt++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL branch_wait_hold: req=%b valid=%b, expected req=0 valid=0", imem_req, if_valid);
    end
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    vec_cnt++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0100) begin
      err_cnt++;
      $display("FAIL branch_stale_drop: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=80000100",
               if_valid, imem_req, imem_addr);
    end
    fetch_word(32'h8000_0100, 32'h0000_0001, "branch_target");
  endtask

  task automatic test_flush_priority();
    stall           = 6'b000001;
    flush           = 1'b1;
    new_pc          = 32'hBFC0_0380;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h8000_0200;
    step();
    flush         = 1'b0;
    branch_flag_i = 1'b0;
    stall         = '0;
    vec_cnt++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 ||
        imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0380) begin
      err_cnt++;
      $display("FAIL flush_prio: valid=%b pc=%h inst=%h req=%b addr=%h, expected valid=0 pc=0 inst=0 req=1 addr=bfc00380",
               if_valid, if_pc, if_inst, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_in_req();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h8000_0300;
    step();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0300) begin
      err_cnt++;
      $display("FAIL req_nogrant_redirect: req=%b addr=%h, expected req=1 addr=80000300", imem_req, imem_addr);
    end
    imem_gnt        = 1'b1;
    branch_target_i = 32'h8000_0400;
    step();
    imem_gnt      = 1'b0;
    branch_flag_i = 1'b0;
    vec_cnt++;
    if (imem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL req_grant_redirect_wait: req=%b, expected req=0", imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    vec_cnt++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0400) begin
      err_cnt++;
      $display("FAIL req_grant_redirect_drop: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=80000400",
               if_valid, imem_req, imem_addr);
    end
    fetch_word(32'h8000_0400, 32'h0123_4567, "redirect_target");
    step();
  endtask

  task automatic test_pc_wrap();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    step();
    branch_flag_i = 1'b0;
    fetch_word(32'hFFFF_FFFC, 32'hAABB_CCDD, "wrap");
    step();
    vec_cnt++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
      err_cnt++;
      $display("FAIL pc_wrap: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=00000000",
               if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h8000_0102;
    step();
    branch_flag_i = 1'b0;
`ifdef IF_ADEL_EXC_EN
    vec_cnt++;
    if (imem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL adel_no_req: req=%b, expected req=0", imem_req);
    end
    step();
    stall = 6'b000001;
    step();
    vec_cnt++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8000_0102 || if_inst !== 32'h0 ||
        if_excepttype !== 32'h0000_2000 || imem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL adel_present: valid=%b pc=%h inst=%h exc=%h req=%b, expected valid=1 pc=80000102 inst=0 exc=00002000 req=0",
               if_valid, if_pc, if_inst, if_excepttype, imem_req);
    end
    flush  = 1'b1;
    new_pc = 32'hBFC0_0380;
    step();
    flush = 1'b0;
    stall = '0;
    vec_cnt++;
    if (if_valid !== 1'b0 || if_excepttype !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0380) begin
      err_cnt++;
      $display("FAIL adel_recover: valid=%b exc=%h req=%b addr=%h, expected valid=0 exc=0 req=1 addr=bfc00380",
               if_valid, if_excepttype, imem_req, imem_addr);
    end
`else
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0100) begin
      err_cnt++;
      $display("FAIL unaligned_addr: req=%b addr=%h, expected req=1 addr=80000100", imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0042_0025;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    vec_cnt++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8000_0102 || if_inst !== 32'h0042_0025 || if_excepttype !== 32'h0) begin
      err_cnt++;
      $display("FAIL unaligned_present: valid=%b pc=%h inst=%h exc=%h, expected valid=1 pc=80000102 inst=00420025 exc=0",
               if_valid, if_pc, if_inst, if_excepttype);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_branch_in_wait();
    test_flush_priority();
    test_redirect_in_req();
    test_pc_wrap();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
